psram_arbiter: RTL and testbench

Two-port round-robin arbiter placed in front of the async PSRAM controller on Nexys4. Serialises independent read/write requests from two user-logic masters (port A, port B) into single-cycle W_REQ/R_REQ pulses for the controller. Tracks each access through the controller's BUSY window and returns completion, plus read data, to the owning port. Also flags a controller that never starts an issued access.

---
 rtl/psram_arbiter_if.sv | 51 +++++
 rtl/psram_arbiter.sv | 149 ++++++++++++++
 tb/tb_psram_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_arbiter_if.sv
// Bus bundle between the two user masters, the arbiter and the async PSRAM controller.
// REQ/GNT: a master raises REQ with WE/ADDR/WDATA stable and keeps them until a one-cycle GNT; DONE closes the access.
interface psram_arbiter_if #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 16
);
    logic                  A_REQ;
    logic                  A_WE;
    logic [ADDR_WIDTH-1:0] A_ADDR;
    logic [DATA_WIDTH-1:0] A_WDATA;
    logic                  A_GNT;
    logic                  A_DONE;
    logic [DATA_WIDTH-1:0] A_RDATA;

    logic                  B_REQ;
    logic                  B_WE;
    logic [ADDR_WIDTH-1:0] B_ADDR;
    logic [DATA_WIDTH-1:0] B_WDATA;
    logic                  B_GNT;
    logic                  B_DONE;
    logic [DATA_WIDTH-1:0] B_RDATA;

    logic [ADDR_WIDTH-1:0] P_WADDR;
    logic [ADDR_WIDTH-1:0] P_RADDR;
    logic [DATA_WIDTH-1:0] P_DIN;
    logic                  P_W_REQ;
    logic                  P_R_REQ;
    logic                  P_BUSY;
    logic [DATA_WIDTH-1:0] P_RDOUT;
    logic                  P_RDOUT_EN;

    // Arbiter side
    modport slave (
        input  A_REQ, A_WE, A_ADDR, A_WDATA,
        output A_GNT, A_DONE, A_RDATA,
        input  B_REQ, B_WE, B_ADDR, B_WDATA,
        output B_GNT, B_DONE, B_RDATA,
        output P_WADDR, P_RADDR, P_DIN, P_W_REQ, P_R_REQ,
        input  P_BUSY, P_RDOUT, P_RDOUT_EN
    );

    // Environment side: user masters plus controller
    modport master (
        output A_REQ, A_WE, A_ADDR, A_WDATA,
        input  A_GNT, A_DONE, A_RDATA,
        output B_REQ, B_WE, B_ADDR, B_WDATA,
        input  B_GNT, B_DONE, B_RDATA,
        input  P_WADDR, P_RADDR, P_DIN, P_W_REQ, P_R_REQ,
        output P_BUSY, P_RDOUT, P_RDOUT_EN
    );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter in front of the async PSRAM controller; tracks each access
// through the controller BUSY window and returns completion and read data to the owner.
module psram_arbiter #(
    parameter int ADDR_WIDTH    = 23,
    parameter int DATA_WIDTH    = 16,
    parameter int START_TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    psram_arbiter_if.slave    bus,
    output logic              ERR,
    output logic [2:0]        dbg_state_o
);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_END   = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t                state_q;
    logic                  ptr_q;    // 0: A has priority on a tie, 1: B
    logic                  owner_q;  // 0: A, 1: B
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CW-1:0]         cnt_q;
    logic                  err_q;
    logic                  a_gnt_q, b_gnt_q, a_done_q, b_done_q;
    logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
    logic [ADDR_WIDTH-1:0] p_waddr_q, p_raddr_q;
    logic [DATA_WIDTH-1:0] p_din_q;
    logic                  p_w_req_q, p_r_req_q;

    logic                  win_b;
    logic                  timeout;
    logic                  finish;
    logic [DATA_WIDTH-1:0] ret_data;

    assign win_b    = bus.B_REQ && (!bus.A_REQ || ptr_q);
    assign timeout  = (state_q == WAIT_START) && !bus.P_BUSY && (cnt_q == CW'(START_TIMEOUT - 1));
    assign finish   = timeout || ((state_q == WAIT_END) && !bus.P_BUSY);
    // Timed-out reads, reads without RDOUT_EN and all writes return zero
    assign ret_data = ((state_q == WAIT_END) && !we_q && bus.P_RDOUT_EN) ? bus.P_RDOUT : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            p_waddr_q <= '0;
            p_raddr_q <= '0;
            p_din_q   <= '0;
            p_w_req_q <= 1'b0;
            p_r_req_q <= 1'b0;
        end else begin
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            p_w_req_q <= 1'b0;
            p_r_req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.A_REQ || bus.B_REQ) begin
                        owner_q <= win_b;
                        we_q    <= win_b ? bus.B_WE    : bus.A_WE;
                        addr_q  <= win_b ? bus.B_ADDR  : bus.A_ADDR;
                        wdata_q <= win_b ? bus.B_WDATA : bus.A_WDATA;
                        a_gnt_q <= !win_b;
                        b_gnt_q <= win_b;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        p_w_req_q <= 1'b1;
                        p_waddr_q <= addr_q;
                        p_din_q   <= wdata_q;
                    end else begin
                        p_r_req_q <= 1'b1;
                        p_raddr_q <= addr_q;
                    end
                    ptr_q   <= !owner_q;
                    cnt_q   <= '0;
                    state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.P_BUSY) begin
                        state_q <= WAIT_END;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_END: begin
                    if (!bus.P_BUSY && !we_q && !bus.P_RDOUT_EN) begin
                        err_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (finish) begin
                if (owner_q) begin
                    b_done_q  <= 1'b1;
                    b_rdata_q <= ret_data;
                end else begin
                    a_done_q  <= 1'b1;
                    a_rdata_q <= ret_data;
                end
                state_q <= DONE;
            end
        end
    end

    assign bus.A_GNT   = a_gnt_q;
    assign bus.B_GNT   = b_gnt_q;
    assign bus.A_DONE  = a_done_q;
    assign bus.B_DONE  = b_done_q;
    assign bus.A_RDATA = a_rdata_q;
    assign bus.B_RDATA = b_rdata_q;
    assign bus.P_WADDR = p_waddr_q;
    assign bus.P_RADDR = p_raddr_q;
    assign bus.P_DIN   = p_din_q;
    assign bus.P_W_REQ = p_w_req_q;
    assign bus.P_R_REQ = p_r_req_q;
    assign ERR         = err_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a small PSRAM controller model on the negative edge.
module tb_psram_arbiter;
  localparam int AW = 23;
  localparam int DW = 16;

  logic       CLK;
  logic       RST;
  logic       ERR;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // controller model state
  logic          stall;
  logic          pend;
  logic          is_rd;
  logic [AW-1:0] rd_addr;
  int            left;
  logic [DW-1:0] mem [0:255];

  psram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  psram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_TIMEOUT(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .ERR         (ERR),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  // controller model: BUSY rises the cycle after a request and lasts 3 cycles
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.P_BUSY = 1'b0; bus.P_RDOUT = '0; bus.P_RDOUT_EN = 1'b0;
    pend = 1'b0; is_rd = 1'b0; rd_addr = '0; left = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        bus.P_BUSY = 1'b0; bus.P_RDOUT_EN = 1'b0; pend = 1'b0; left = 0;
      end else begin
        bus.P_RDOUT_EN = 1'b0;
        if (pend) begin
          bus.P_BUSY = 1'b1; left = 3; pend = 1'b0;
        end else if (bus.P_BUSY) begin
          left--;
          if (left == 0) begin
            bus.P_BUSY = 1'b0;
            if (is_rd) begin
              bus.P_RDOUT_EN = 1'b1;
              bus.P_RDOUT = mem[rd_addr[7:0]];
            end
          end
        end
        if (bus.P_W_REQ && !stall) begin
          pend = 1'b1; is_rd = 1'b0; mem[bus.P_WADDR[7:0]] = bus.P_DIN;
        end
        if (bus.P_R_REQ && !stall) begin
          pend = 1'b1; is_rd = 1'b1; rd_addr = bus.P_RADDR;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_gnt"},   32'(bus.A_GNT),   32'h0);
    chk({tag, "_b_gnt"},   32'(bus.B_GNT),   32'h0);
    chk({tag, "_a_done"},  32'(bus.A_DONE),  32'h0);
    chk({tag, "_b_done"},  32'(bus.B_DONE),  32'h0);
    chk({tag, "_a_rdata"}, 32'(bus.A_RDATA), 32'h0);
    chk({tag, "_b_rdata"}, 32'(bus.B_RDATA), 32'h0);
    chk({tag, "_waddr"},   32'(bus.P_WADDR), 32'h0);
    chk({tag, "_raddr"},   32'(bus.P_RADDR), 32'h0);
    chk({tag, "_din"},     32'(bus.P_DIN),   32'h0);
    chk({tag, "_wreq"},    32'(bus.P_W_REQ), 32'h0);
    chk({tag, "_rreq"},    32'(bus.P_R_REQ), 32'h0);
    chk({tag, "_err"},     32'(ERR),         32'h0);
  endtask

  task automatic set_req(input bit port, input bit req, input bit we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (port) begin
      bus.B_REQ = req; bus.B_WE = we; bus.B_ADDR = addr; bus.B_WDATA = wd;
    end else begin
      bus.A_REQ = req; bus.A_WE = we; bus.A_ADDR = addr; bus.A_WDATA = wd;
    end
  endtask

  // One complete access with the 3-cycle BUSY model; called with the arbiter in IDLE.
  task automatic do_access(input string tag, input bit port, input bit we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] exp_rd);
    logic [DW-1:0] other_rd;
    other_rd = port ? bus.A_RDATA : bus.B_RDATA;
    set_req(port, 1'b1, we, addr, wd);
    @(negedge CLK);
    chk({tag, "_gnt"},  32'(port ? bus.B_GNT : bus.A_GNT), 32'h1);
    chk({tag, "_ogn"},  32'(port ? bus.A_GNT : bus.B_GNT), 32'h0);
    set_req(port, 1'b0, we, addr, wd);
    @(negedge CLK);
    chk({tag, "_wreq"}, 32'(bus.P_W_REQ), 32'(we));
    chk({tag, "_rreq"}, 32'(bus.P_R_REQ), 32'(!we));
    if (we) begin
      chk({tag, "_waddr"}, 32'(bus.P_WADDR), 32'(addr));
      chk({tag, "_din"},   32'(bus.P_DIN),   32'(wd));
    end else begin
      chk({tag, "_raddr"}, 32'(bus.P_RADDR), 32'(addr));
    end
    @(negedge CLK);
    chk({tag, "_req_lo"}, 32'(bus.P_W_REQ | bus.P_R_REQ), 32'h0);
    repeat (3) @(negedge CLK);
    chk({tag, "_early"}, 32'(port ? bus.B_DONE : bus.A_DONE), 32'h0);
    @(negedge CLK);
    chk({tag, "_done"},  32'(port ? bus.B_DONE : bus.A_DONE), 32'h1);
    chk({tag, "_odone"}, 32'(port ? bus.A_DONE : bus.B_DONE), 32'h0);
    chk({tag, "_rdata"}, 32'(port ? bus.B_RDATA : bus.A_RDATA), 32'(exp_rd));
    chk({tag, "_ordat"}, 32'(port ? bus.A_RDATA : bus.B_RDATA), 32'(other_rd));
    @(negedge CLK);
    chk({tag, "_dn_lo"}, 32'(port ? bus.B_DONE : bus.A_DONE), 32'h0);
  endtask

  initial begin
    int         n_gnt;
    int         n_done;
    int         clash;
    logic [5:0] order;
    stall = 1'b0;
    RST   = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);

    // reset: everything zero, no requests issued while idle
    repeat (2) @(negedge CLK);
    chk_all_zero("rst");
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("idle_req", 32'(bus.P_W_REQ | bus.P_R_REQ | bus.A_GNT | bus.B_GNT), 32'h0);
    end
    chk("idle_state", 32'(dbg_state), 32'h0);

    // A write then B read of the same word
    do_access("a_wr", 1'b0, 1'b1, 23'h000010, 16'hBEEF, 16'h0000);
    do_access("b_rd", 1'b1, 1'b0, 23'h000010, 16'h0000, 16'hBEEF);

    // both masters request continuously from reset: A, B, A, B, A, B
    do_reset();
    set_req(1'b0, 1'b1, 1'b1, 23'h000020, 16'h1234);
    set_req(1'b1, 1'b1, 1'b0, 23'h000020, 16'h0000);
    n_gnt = 0; n_done = 0; clash = 0; order = '0;
    for (int c = 0; c < 120 && n_done < 6; c++) begin
      @(negedge CLK);
      if (bus.P_W_REQ && bus.P_R_REQ) clash++;
      if (bus.A_GNT && bus.B_GNT) clash++;
      if (bus.A_DONE || bus.B_DONE) n_done++;
      if ((bus.A_GNT || bus.B_GNT) && n_gnt < 6) begin
        order[n_gnt] = bus.B_GNT;
        n_gnt++;
        if (n_gnt == 6) begin
          bus.A_REQ = 1'b0;
          bus.B_REQ = 1'b0;
        end
      end
    end
    chk("rr_ngnt",  32'(n_gnt),  32'd6);
    chk("rr_ndone", 32'(n_done), 32'd6);
    chk("rr_order", 32'(order),  32'b101010);
    chk("rr_clash", 32'(clash),  32'd0);
    chk("rr_brd",   32'(bus.B_RDATA), 32'h1234);
    @(negedge CLK);

    // controller never starts a read: ERR after 4 waiting cycles, data 0
    do_access("a_rd", 1'b0, 1'b0, 23'h000020, 16'h0000, 16'h1234);
    stall = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 23'h000030, 16'h0000);
    @(negedge CLK);
    chk("to_gnt", 32'(bus.A_GNT), 32'h1);
    bus.A_REQ = 1'b0;
    @(negedge CLK);
    chk("to_rreq",  32'(bus.P_R_REQ), 32'h1);
    chk("to_raddr", 32'(bus.P_RADDR), 32'h30);
    repeat (3) @(negedge CLK);
    chk("to_err_lo", 32'(ERR),        32'h0);
    chk("to_dn_lo",  32'(bus.A_DONE), 32'h0);
    @(negedge CLK);
    chk("to_err",   32'(ERR),         32'h1);
    chk("to_done",  32'(bus.A_DONE),  32'h1);
    chk("to_rdata", 32'(bus.A_RDATA), 32'h0);
    @(negedge CLK);
    stall = 1'b0;
    do_access("after_to", 1'b1, 1'b0, 23'h000020, 16'h0000, 16'h1234);
    chk("err_sticky", 32'(ERR), 32'h1);

    // reset in WAIT_END of a read: all outputs zero, no DONE, then normal service
    set_req(1'b0, 1'b1, 1'b0, 23'h000020, 16'h0000);
    @(negedge CLK);
    bus.A_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    chk("mid_state", 32'(dbg_state), 32'd3);
    RST = 1'b1;
    @(negedge CLK);
    chk_all_zero("mid_rst");
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      chk("mid_nodone", 32'(bus.A_DONE | bus.B_DONE), 32'h0);
    end
    do_access("post_wr", 1'b1, 1'b1, 23'h000040, 16'h5A5A, 16'h0000);
    do_access("post_rd", 1'b0, 1'b0, 23'h000040, 16'h0000, 16'h5A5A);
    chk("post_err", 32'(ERR), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
